// File: rtl/apb_master_bridge.sv
// APB requester: turns single-beat client commands into SETUP/ACCESS transfers,
// returning read data and error status through a one-cycle response strobe.
module apb_master_bridge #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSel,
    output logic              PEnable,
    output logic              PWrite,
    output logic [ADDR_W-1:0] PAddress,
    output logic [DATA_W-1:0] PWData,
    input  logic [DATA_W-1:0] PRData,
    input  logic              PReady,
    input  logic              PSLERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic [7:0]          wait_inc;

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;
        // Saturating increment: the counter must never wrap back to zero.
        wait_inc    = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    wait_cnt_d = 8'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready responder wins over a timeout reached on the same edge.
                if (PReady) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRData;
                    rsp_err_d   = PSLERR;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= TIMEOUT_C) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSel      = (state_q != IDLE);
    assign PEnable   = (state_q == ACCESS);
    assign PWrite    = pwrite_q;
    assign PAddress  = paddr_q;
    assign PWData    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a driver issues commands and pushes
// expected responses; a negedge monitor checks bus phases and responses.
module tb_apb_master_bridge;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          resetN;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSel;
    logic          PEnable;
    logic          PWrite;
    logic [AW-1:0] PAddress;
    logic [DW-1:0] PWData;
    logic [DW-1:0] PRData;
    logic          PReady;
    logic          PSLERR;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .resetN(resetN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSel(PSel), .PEnable(PEnable), .PWrite(PWrite), .PAddress(PAddress),
        .PWData(PWData), .PRData(PRData), .PReady(PReady), .PSLERR(PSLERR)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference view of the transfer in flight: bus busy strictly between
    // the accept cycle and the response cycle.
    int            win_start = -10;
    int            win_end = -10;
    logic          cur_write = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    int            cur_wait = 0;
    logic          cur_perr = 1'b0;
    logic [DW-1:0] cur_prdata = '0;
    int            access_cnt = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder: holds PReady low for cur_wait ACCESS cycles, junk elsewhere.
    always @(negedge clock) begin
        if (PSel && PEnable) begin
            if (access_cnt < cur_wait) begin
                PReady = 1'b0;
                PSLERR = 1'($urandom);
                PRData = DW'($urandom);
            end else begin
                PReady = 1'b1;
                PSLERR = cur_perr;
                PRData = cur_prdata;
            end
            access_cnt++;
        end else begin
            access_cnt = 0;
            PReady = 1'($urandom);
            PSLERR = 1'($urandom);
            PRData = DW'($urandom);
        end
    end

    // Monitor
    always @(negedge clock) begin
        logic exp_psel;
        logic exp_pen;
        exp_t e;
        if (resetN) begin
            exp_psel = (cyc > win_start) && (cyc < win_end);
            exp_pen  = (cyc > win_start + 1) && (cyc < win_end);
            chk("psel", {31'd0, PSel}, {31'd0, exp_psel});
            chk("penable", {31'd0, PEnable}, {31'd0, exp_pen});
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !exp_psel});
            if (PSel) begin
                chk("paddr", 32'(PAddress), 32'(cur_addr));
                chk("pwdata", 32'(PWData), 32'(cur_wdata));
                chk("pwrite", {31'd0, PWrite}, {31'd0, cur_write});
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing: got no rsp_valid expected one at cycle %0d (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int w, input logic perr, input logic [DW-1:0] prd,
                         output int acc);
        int   n;
        exp_t e;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clock);
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: got cmd_ready=0 expected 1 within 200 cycles");
            acc = -1;
        end else begin
            acc        = cyc;
            cur_write  = wr;
            cur_addr   = a;
            cur_wdata  = d;
            cur_wait   = w;
            cur_perr   = perr;
            cur_prdata = prd;
            if (w >= TO) begin
                e.cyc   = acc + 2 + TO;
                e.rdata = '0;
                e.err   = 1'b1;
            end else begin
                e.cyc   = acc + 3 + w;
                e.rdata = wr ? '0 : prd;
                e.err   = perr;
            end
            win_start = acc;
            win_end   = e.cyc;
            sb.push_back(e);
            $display("cmd cyc=%0d %s addr=%0h wdata=%0h waits=%0d perr=%0d prdata=%0h -> rsp@%0d rdata=%0h err=%0d",
                     acc, wr ? "WR" : "RD", a, d, w, perr, prd, e.cyc, e.rdata, e.err);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_psel", {31'd0, PSel}, 32'd0);
        chk("rst_penable", {31'd0, PEnable}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_pwrite", {31'd0, PWrite}, 32'd0);
        chk("rst_paddr", 32'(PAddress), 32'd0);
        chk("rst_pwdata", 32'(PWData), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        int acc1;
        int acc2;
        int w;
        int gap;
        resetN = 1'b0;
        go_idle();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;

        // Zero-wait write, zero-wait read, wait states with error
        issue(1'b1, 9'h0A5, 16'hBEEF, 0, 1'b0, 16'h5555, acc1);
        go_idle();
        drain();
        issue(1'b0, 9'h012, 16'h0000, 0, 1'b0, 16'h1234, acc1);
        go_idle();
        drain();
        issue(1'b0, 9'h0C3, 16'h0000, 4, 1'b1, 16'hA5A5, acc1);
        go_idle();
        drain();

        // Timeout, and PReady arriving on the edge the counter reaches TIMEOUT
        issue(1'b0, 9'h1FF, 16'h0000, TO + 5, 1'b0, 16'hCAFE, acc1);
        go_idle();
        drain();
        issue(1'b0, 9'h100, 16'h0000, TO - 1, 1'b0, 16'h7E57, acc1);
        go_idle();
        drain();

        // Reset in the middle of ACCESS drops the transfer immediately
        issue(1'b1, 9'h055, 16'h3C3C, 100, 1'b0, 16'h0000, acc1);
        go_idle();
        repeat (4) @(posedge clock);
        #2;
        resetN    = 1'b0;
        win_start = -10;
        win_end   = -10;
        void'(sb.pop_back());
        #1;
        check_reset_values();
        @(posedge clock);
        #2;
        resetN = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Back-to-back reads with cmd_valid held high
        issue(1'b0, 9'h001, 16'h0000, 0, 1'b0, 16'h0101, acc1);
        issue(1'b0, 9'h002, 16'h0000, 0, 1'b0, 16'h0202, acc2);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);
        go_idle();
        drain();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 9);
            if (w == 8) w = TO - 1;
            else if (w == 9) w = TO + $urandom_range(0, 3);
            else w = w % 6;
            issue(1'($urandom), AW'($urandom), DW'($urandom), w, 1'($urandom), DW'($urandom), acc1);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                go_idle();
                repeat (gap) @(posedge clock);
                #1;
            end
        end
        go_idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
